// File: rtl/pmodadc_pkg.sv
// Shared defaults and state encodings for the PmodADC SAR controller and its
// reference shift-register serialiser.
package pmodadc_pkg;

    localparam int unsigned DefResBits  = 14;
    localparam int unsigned DefSregBits = 16;
    localparam int unsigned AlignShift  = DefSregBits - DefResBits;

    typedef enum logic [2:0] {
        StIdle,
        StHold,
        StShift,
        StLatch,
        StSettle,
        StDecide,
        StDone
    } sar_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxShift,
        TxLatch
    } tx_state_e;

endpackage

// File: rtl/sreg_tx.sv
// Generic serialiser for an external shift register: shifts a word MSB-first on
// ser/sclk, then pulses lclk; every phase lasts CLK_DIV clock cycles.
module sreg_tx
    import pmodadc_pkg::*;
#(
    parameter int unsigned SREG_BITS = DefSregBits,
    parameter int unsigned CLK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [SREG_BITS-1:0] data,
    output logic                 ser,
    output logic                 sclk,
    output logic                 lclk,
    output logic                 shift_done,
    output logic                 done
);

    localparam int unsigned     DivW    = $clog2(CLK_DIV + 1);
    localparam int unsigned     BitW    = $clog2(SREG_BITS + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(SREG_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [SREG_BITS-1:0] shreg_q, shreg_d;
    logic [DivW-1:0]      div_q, div_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic                 phase_q, phase_d;  // 0: SClk low half, 1: SClk high half

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TxIdle;
            shreg_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        div_d      = div_q;
        bit_d      = bit_q;
        phase_d    = phase_q;
        ser        = 1'b0;
        sclk       = 1'b0;
        lclk       = 1'b0;
        shift_done = 1'b0;
        done       = 1'b0;
        case (state_q)
            TxIdle: begin
                if (load) begin
                    state_d = TxShift;
                    shreg_d = data;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end
            end
            TxShift: begin
                ser  = shreg_q[SREG_BITS-1];
                sclk = phase_q;
                if (div_q == DivLast) begin
                    div_d   = '0;
                    phase_d = ~phase_q;
                    // Advancing the word on the high->low transition keeps Ser
                    // changes confined to SClk-low time.
                    if (phase_q) begin
                        if (bit_q == BitLast) begin
                            shift_done = 1'b1;
                            state_d    = TxLatch;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shreg_d = shreg_q << 1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            TxLatch: begin
                lclk = 1'b1;
                if (div_q == DivLast) begin
                    div_d   = '0;
                    done    = 1'b1;
                    state_d = TxIdle;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = TxIdle;
        endcase
    end

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives trial codes into the PmodADC
// reference shift register and resolves one result bit per comparator decision.
module sar_adc_ctrl
    import pmodadc_pkg::*;
#(
    parameter int unsigned RES_BITS      = DefResBits,
    parameter int unsigned SREG_BITS     = DefSregBits,
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                valid_o,
    output logic [RES_BITS-1:0] result_o,
    output logic                ADC_SH_o,
    output logic                ADC_Ser_o,
    output logic                ADC_SClk_o,
    output logic                ADC_LClk_o,
    input  logic                ADC_Comp_i
);

    localparam int unsigned     Align   = SREG_BITS - RES_BITS;
    localparam int unsigned     IdxW    = (RES_BITS > 1) ? $clog2(RES_BITS) : 1;
    localparam int unsigned     SetW    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IdxW-1:0] IdxTop  = IdxW'(RES_BITS - 1);
    localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYCLES - 1);

    sar_state_e           state_q, state_d;
    logic [RES_BITS-1:0]  code_q, code_d;
    logic [RES_BITS-1:0]  result_q, result_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [SetW-1:0]      settle_q, settle_d;
    logic [RES_BITS-1:0]  trial;
    logic [SREG_BITS-1:0] trial_word;
    logic                 tx_load, tx_shift_done, tx_done;

    // The trial loaded alongside a state change must reflect the updated code/index.
    assign trial      = code_d | (RES_BITS'(1) << idx_d);
    assign trial_word = SREG_BITS'(trial) << Align;
    assign result_o   = result_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            code_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        result_d = result_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        tx_load  = 1'b0;
        busy_o   = 1'b1;
        valid_o  = 1'b0;
        ADC_SH_o = 1'b0;
        case (state_q)
            StIdle: begin
                busy_o   = 1'b0;
                ADC_SH_o = 1'b1;
                if (start_i) begin
                    code_d  = '0;
                    idx_d   = IdxTop;
                    state_d = StHold;
                end
            end
            StHold: begin
                tx_load = 1'b1;
                state_d = StShift;
            end
            StShift: begin
                if (tx_shift_done) state_d = StLatch;
            end
            StLatch: begin
                if (tx_done) begin
                    settle_d = '0;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (settle_q == SetLast) state_d = StDecide;
                else settle_d = settle_q + 1'b1;
            end
            StDecide: begin
                if (ADC_Comp_i) code_d = code_q | (RES_BITS'(1) << idx_q);
                if (idx_q == '0) begin
                    // Result is written here so it is already valid during DONE.
                    result_d = code_d;
                    state_d  = StDone;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    tx_load = 1'b1;
                    state_d = StShift;
                end
            end
            StDone: begin
                busy_o   = 1'b0;
                valid_o  = 1'b1;
                ADC_SH_o = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    sreg_tx #(
        .SREG_BITS(SREG_BITS),
        .CLK_DIV  (CLK_DIV)
    ) u_sreg_tx (
        .clk       (clk_i),
        .reset     (reset_i),
        .load      (tx_load),
        .data      (trial_word),
        .ser       (ADC_Ser_o),
        .sclk      (ADC_SClk_o),
        .lclk      (ADC_LClk_o),
        .shift_done(tx_shift_done),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: models the external shift register and an
// ideal comparator (latched word <= VIN) and checks results and pin timing.
module tb_sar_adc_ctrl;

    localparam int T_BIT   = 2 * 16 * 2 + 2 + 8 + 1;  // 75
    localparam int LATENCY = 2 + 14 * T_BIT;           // 1052
    localparam int B2B     = 3 + 14 * T_BIT;           // DONE + IDLE + HOLD + trials

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        comp;
    logic        busy, valid, sh, ser, sclk, lclk;
    logic [13:0] result;
    logic [15:0] vin = '0;
    logic [15:0] latched = '0;
    logic [15:0] model_sr = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign comp = (latched <= vin);

    sar_adc_ctrl dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .busy_o    (busy),
        .valid_o   (valid),
        .result_o  (result),
        .ADC_SH_o  (sh),
        .ADC_Ser_o (ser),
        .ADC_SClk_o(sclk),
        .ADC_LClk_o(lclk),
        .ADC_Comp_i(comp)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pin monitor: shift-register model plus per-trial SClk/LClk timing checks.
    logic        p_sclk = 1'b0, p_lclk = 1'b0, p_ser = 1'b0;
    int          rises = 0, per_bad = 0, ser_bad = 0, last_rise = 0, lclk_rise = 0;
    int          valid_cnt = 0;
    logic [15:0] words[$];
    int          valid_cyc[$];

    always @(posedge clk) begin
        #1;
        if (reset) begin
            rises   = 0;
            per_bad = 0;
            ser_bad = 0;
            p_sclk  = 1'b0;
            p_lclk  = 1'b0;
            p_ser   = 1'b0;
        end else begin
            if (sclk && !p_sclk) begin
                model_sr = {model_sr[14:0], ser};
                if (rises > 0 && cyc - last_rise != 4) per_bad++;
                last_rise = cyc;
                rises++;
            end
            if (sclk && p_sclk && ser !== p_ser) ser_bad++;
            if (lclk && !p_lclk) begin
                latched = model_sr;
                words.push_back(model_sr);
                check_eq("sclk_rises_per_lclk", 32'(rises), 32'd16);
                check_eq("sclk_period_errors", 32'(per_bad), 32'd0);
                check_eq("ser_change_while_sclk_high", 32'(ser_bad), 32'd0);
                check_eq("lclk_rise_with_sclk_fall", 32'(p_sclk && !sclk), 32'd1);
                rises     = 0;
                per_bad   = 0;
                ser_bad   = 0;
                lclk_rise = cyc;
            end
            if (!lclk && p_lclk) check_eq("lclk_width", 32'(cyc - lclk_rise), 32'd2);
            if (valid) begin
                valid_cnt++;
                valid_cyc.push_back(cyc);
            end
            p_sclk = sclk;
            p_lclk = lclk;
            p_ser  = ser;
        end
    end

    // Main flow samples/drives after the monitor has run for the same edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_valid"}, 32'(valid), 32'd0);
        check_eq({tag, "_result"}, 32'(result), 32'd0);
        check_eq({tag, "_sh"}, 32'(sh), 32'd1);
        check_eq({tag, "_ser"}, 32'(ser), 32'd0);
        check_eq({tag, "_sclk"}, 32'(sclk), 32'd0);
        check_eq({tag, "_lclk"}, 32'(lclk), 32'd0);
    endtask

    task automatic run_conv(input logic [15:0] v, input logic [13:0] exp, input string tag,
                            input int mid_start);
        int k;
        bit seen;
        vin = v;
        words.delete();
        valid_cnt = 0;
        start = 1'b1;
        k = cyc;
        tick();
        start = 1'b0;
        check_eq({tag, "_busy_rise"}, 32'(busy), 32'd1);
        check_eq({tag, "_sh_hold"}, 32'(sh), 32'd0);
        seen = 1'b0;
        for (int n = 1; n < 1200 && !seen; n++) begin
            start = (mid_start != 0 && n == mid_start);
            tick();
            if (valid) begin
                seen = 1'b1;
                check_eq({tag, "_latency"}, 32'(cyc - k), 32'(LATENCY));
                check_eq({tag, "_result"}, 32'(result), 32'(exp));
                check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
                check_eq({tag, "_sh_done"}, 32'(sh), 32'd1);
            end
        end
        start = 1'b0;
        if (!seen) check_eq({tag, "_valid_timeout"}, 32'd0, 32'd1);
        repeat (4) tick();
        check_eq({tag, "_valid_count"}, 32'(valid_cnt), 32'd1);
        check_eq({tag, "_trial_count"}, 32'(words.size()), 32'd14);
        check_eq({tag, "_result_held"}, 32'(result), 32'(exp));
    endtask

    task automatic wait_valids(input int target, input string tag);
        int n;
        n = 0;
        while (valid_cnt < target && n < 1200) begin
            tick();
            n++;
        end
        if (valid_cnt < target) check_eq({tag, "_valid_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1'b1;
        repeat (3) tick();
        check_reset_values("por");
        reset = 1'b0;
        tick();

        run_conv(16'h2A52, 14'h0A94, "vin2a52", 0);
        if (words.size() >= 4) begin
            check_eq("word0", 32'(words[0]), 32'h8000);
            check_eq("word1", 32'(words[1]), 32'h4000);
            check_eq("word2", 32'(words[2]), 32'h2000);
            check_eq("word3", 32'(words[3]), 32'h3000);
        end
        run_conv(16'h0000, 14'h0000, "vin0000", 0);
        run_conv(16'hFFFF, 14'h3FFF, "vinffff", 0);
        run_conv(16'h2A52, 14'h0A94, "mid_start", 300);

        // Reset 500 cycles into a conversion.
        vin = 16'h2A52;
        valid_cnt = 0;
        start = 1'b1;
        k = cyc;
        tick();
        start = 1'b0;
        while (cyc < k + 500) tick();
        reset = 1'b1;
        tick();
        check_reset_values("mid_reset");
        reset = 1'b0;
        repeat (1100) tick();
        check_eq("mid_reset_no_valid", 32'(valid_cnt), 32'd0);
        check_eq("mid_reset_result", 32'(result), 32'd0);
        run_conv(16'h2A52, 14'h0A94, "after_reset", 0);

        // start held high: back-to-back conversions.
        vin = 16'h1000;
        valid_cnt = 0;
        valid_cyc.delete();
        start = 1'b1;
        wait_valids(1, "b2b_first");
        check_eq("b2b_first_result", 32'(result), 32'h0400);
        vin = 16'h2A52;
        repeat (3) tick();
        start = 1'b0;
        wait_valids(2, "b2b_second");
        check_eq("b2b_second_result", 32'(result), 32'h0A94);
        if (valid_cyc.size() >= 2)
            check_eq("b2b_spacing", 32'(valid_cyc[1] - valid_cyc[0]), 32'(B2B));
        repeat (4) tick();
        check_eq("b2b_valid_count", 32'(valid_cnt), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
